// File: rtl/div_seq_ctrl_if.sv
// Execute-stage divide request/response bundle shared by the pipeline and
// the iterative divide sequencer.
interface div_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  // Handshake: start is taken only when the sequencer is not busy (IDLE or
  // DONE) and flush is low. A taken start is answered by exactly one done
  // pulse, with result valid in that cycle and held until the next done.
  logic             start;
  logic [1:0]       funct;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, funct, srca, srcb, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct, srca, srcb, flush,
    output busy, done, result
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Radix-2 restoring divide sequencer for DIV/DIVU/REM/REMU with a one-cycle
// fast path for divide-by-zero and signed overflow.
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  div_seq_ctrl_if.slave    bus,
  output logic [2:0]       o_state
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_funct;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_div;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_min;
  logic             w_div0;
  logic             w_ovf;
  logic [WIDTH-1:0] w_fast_res;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH-1:0] w_fix_res;

  assign w_min      = {1'b1, {(WIDTH-1){1'b0}}};
  assign w_div0     = (bus.srcb == '0);
  assign w_ovf      = !bus.funct[0] && (bus.srca == w_min) && (bus.srcb == {WIDTH{1'b1}});
  assign w_fast_res = w_div0 ? (bus.funct[1] ? bus.srca : {WIDTH{1'b1}})
                             : (bus.funct[1] ? '0 : bus.srca);

  // funct[0]=0 selects the signed flavours (DIV, REM).
  assign w_sa    = !r_funct[0] && r_a[WIDTH-1];
  assign w_sb    = !r_funct[0] && r_b[WIDTH-1];
  assign w_mag_a = w_sa ? (-r_a) : r_a;
  assign w_mag_b = w_sb ? (-r_b) : r_b;

  // The shifted partial remainder can exceed WIDTH bits, so trial in WIDTH+1.
  assign w_rem_sh = {r_rem, r_quot[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_div};

  assign w_q_fix   = r_sign_q ? (-r_quot) : r_quot;
  assign w_r_fix   = r_sign_r ? (-r_rem) : r_rem;
  assign w_fix_res = r_funct[1] ? w_r_fix : w_q_fix;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_funct  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_div    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (bus.start) begin
              r_funct <= bus.funct;
              r_a     <= bus.srca;
              r_b     <= bus.srcb;
              if (w_div0 || w_ovf) begin
                r_state  <= S_DONE;
                r_result <= w_fast_res;
                r_done   <= 1'b1;
                r_busy   <= 1'b0;
              end else begin
                r_state <= S_PREP;
                r_busy  <= 1'b1;
              end
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          S_PREP: begin
            r_quot   <= w_mag_a;
            r_rem    <= '0;
            r_div    <= w_mag_b;
            r_sign_q <= w_sa ^ w_sb;
            r_sign_r <= w_sa;
            r_cnt    <= '0;
            r_state  <= S_ITER;
          end
          S_ITER: begin
            if (!w_trial[WIDTH]) begin
              r_rem  <= w_trial[WIDTH-1:0];
              r_quot <= {r_quot[WIDTH-2:0], 1'b1};
            end else begin
              r_rem  <= w_rem_sh[WIDTH-1:0];
              r_quot <= {r_quot[WIDTH-2:0], 1'b0};
            end
            if (r_cnt == CW'(WIDTH-1)) begin
              r_cnt   <= '0;
              r_state <= S_FIX;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_FIX: begin
            r_result <= w_fix_res;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign o_state    = r_state;
endmodule
